mux4_rr_sel: RTL and testbench

- Select-line generator directly upstream of the 4:1 data multiplexer; drives its two select lines S1, S2.
- Four sources request the mux output; the block grants one at a time using round-robin arbitration.
- Each grant has a minimum dwell time and an optional maximum hold timeout.
- Registered, one-hot grant feedback and a valid flag let the sources and the downstream consumer know who currently owns the mux.

---
 rtl/mux4_rr_sel_if.sv | 14 +
 rtl/mux4_rr_sel.sv | 104 ++++++++++
 tb/tb_mux4_rr_sel.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_sel_if.sv
// Handshake bundle between the four requesting sources and the mux select generator.
// The slave modport is the arbiter side and the master modport is the source/consumer side.
interface mux4_rr_sel_if;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic       S1;
  logic       S2;
  logic [3:0] gnt;
  logic       valid;

  modport master (output en, req, done, input S1, S2, gnt, valid);
  modport slave  (input en, req, done, output S1, S2, gnt, valid);
endinterface

// File: rtl/mux4_rr_sel.sv
// Round-robin select-line generator for a 4:1 data mux.
// Each grant has a minimum dwell and an optional forced-release timeout.
module mux4_rr_sel #(
  parameter int DWELL    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mux4_rr_sel_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
  localparam logic [7:0] HOLD_M1  = 8'(MAX_HOLD - 1);

  state_t     state, state_n;
  logic [1:0] last, last_n;
  logic [1:0] sel, sel_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] gnt_r, gnt_n;
  logic       valid_r, valid_n;

  logic       found;
  logic [1:0] pick;
  logic       rel_ok, tmo;
  logic       grant, drop;

  // While busy, last is the current owner, so one search from last+1 serves
  // both the idle case and the release case; the owner is visited last.
  always_comb begin
    found = 1'b0;
    pick  = last;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req[last + 2'(k)]) begin
        found = 1'b1;
        pick  = last + 2'(k);
      end
    end
  end

  assign rel_ok = (cnt >= DWELL_M1) && (bus.done || !bus.req[last]);
  assign tmo    = (MAX_HOLD != 0) && (cnt == HOLD_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 2'd3;
      sel     <= 2'd0;
      cnt     <= 8'd0;
      gnt_r   <= 4'b0000;
      valid_r <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      sel     <= sel_n;
      cnt     <= cnt_n;
      gnt_r   <= gnt_n;
      valid_r <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    sel_n   = sel;
    cnt_n   = cnt;
    gnt_n   = gnt_r;
    valid_n = valid_r;
    grant   = 1'b0;
    drop    = 1'b0;

    case (state)
      IDLE: grant = bus.en && found;
      BUSY: begin
        if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
        if (!bus.en)              drop = 1'b1;
        else if (rel_ok || tmo) begin
          if (found) grant = 1'b1;
          else       drop  = 1'b1;
        end
      end
      default: drop = 1'b1;
    endcase

    if (grant) begin
      state_n = BUSY;
      last_n  = pick;
      sel_n   = pick;
      cnt_n   = 8'd0;
      gnt_n   = 4'b0001 << pick;
      valid_n = 1'b1;
    end else if (drop) begin
      // sel is left alone so the mux keeps its last routing while idle
      state_n = IDLE;
      gnt_n   = 4'b0000;
      valid_n = 1'b0;
    end
  end

  assign bus.S1    = sel[1];
  assign bus.S2    = sel[0];
  assign bus.gnt   = gnt_r;
  assign bus.valid = valid_r;
endmodule

// File: tb/tb_mux4_rr_sel.sv
// Self-checking bench for mux4_rr_sel: directed vector table, timeout/reset
// sequences, and random traffic against a behavioural arbitration model.
module tb_mux4_rr_sel;
  localparam int DWELL    = 4;
  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux4_rr_sel_if bus ();
  mux4_rr_sel #(.DWELL(DWELL), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } vec_t;
  vec_t vecs[$];

  int errors = 0;
  int checks = 0;

  // behavioural model state: owner index, round-robin memory, dwell count, mux routing
  bit m_busy;
  int m_own, m_last, m_cnt, m_sel;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int find(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_last = 3; m_cnt = 0; m_sel = 0;
  endtask

  task automatic model_grant(input int p);
    m_busy = 1; m_own = p; m_last = p; m_sel = p; m_cnt = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] r, input logic d);
    int  p;
    bit  rel;
    if (!m_busy) begin
      p = find(m_last + 1, r);
      if (e && p >= 0) model_grant(p);
    end else if (!e) begin
      m_busy = 0;
    end else begin
      rel = ((m_cnt >= DWELL - 1) && (d || !r[m_own])) ||
            ((MAX_HOLD != 0) && (m_cnt == MAX_HOLD - 1));
      if (rel) begin
        p = find(m_own + 1, r);
        if (p >= 0) model_grant(p);
        else        m_busy = 0;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_gnt"},   int'(bus.gnt), m_busy ? (1 << m_own) : 0);
    chk({tag, "_valid"}, int'(bus.valid), int'(m_busy));
    chk({tag, "_sel"},   int'({bus.S1, bus.S2}), m_sel);
  endtask

  task automatic cycle(input logic e, input logic [3:0] r, input logic d);
    bus.en = e; bus.req = r; bus.done = d;
    @(posedge clk);
    model_step(e, r, d);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.req = 4'b0; bus.done = 1'b0;
    #3;
    model_reset();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_sel", int'({bus.S1, bus.S2}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic e, input logic [3:0] r, input logic d,
                     input logic [3:0] g, input logic [1:0] s, input logic v);
    vec_t t;
    t.en = e; t.req = r; t.done = d; t.gnt = g; t.sel = s; t.valid = v;
    vecs.push_back(t);
  endtask

  initial begin
    // first grant, dwell enforcement, then release to source 2
    add(1, 4'b0101, 0, 4'b0001, 2'd0, 1);
    add(1, 4'b0101, 0, 4'b0001, 2'd0, 1);
    add(1, 4'b0101, 1, 4'b0001, 2'd0, 1);
    add(1, 4'b0101, 0, 4'b0001, 2'd0, 1);
    add(1, 4'b0101, 1, 4'b0100, 2'd2, 1);
    // round robin with all requesting, done at cnt = DWELL-1
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 3; c++)
        add(1, 4'b1111, 0, 4'b0001 << ((2 + o) % 4), 2'((2 + o) % 4), 1);
      add(1, 4'b1111, 1, 4'b0001 << ((3 + o) % 4), 2'((3 + o) % 4), 1);
    end
    // sole owner drops req after dwell, then en = 0 blocks grants
    add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    add(1, 4'b0000, 0, 4'b0000, 2'd2, 0);
    add(0, 4'b1111, 0, 4'b0000, 2'd2, 0);
    add(0, 4'b1111, 0, 4'b0000, 2'd2, 0);
    // last = 2 so the search starts at 3 and finds source 1; en drop at cnt = 0
    add(1, 4'b0010, 0, 4'b0010, 2'd1, 1);
    add(0, 4'b0010, 0, 4'b0000, 2'd1, 0);

    do_reset();
    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d_gnt", i), int'(bus.gnt), int'(vecs[i].gnt));
      chk($sformatf("vec%0d_sel", i), int'({bus.S1, bus.S2}), int'(vecs[i].sel));
      chk($sformatf("vec%0d_valid", i), int'(bus.valid), int'(vecs[i].valid));
    end
    check_model("post_vec");

    // asynchronous reset in the middle of a grant
    cycle(1, 4'b0101, 0);
    chk("pre_async_gnt", int'(bus.gnt), 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_gnt", int'(bus.gnt), 0);
    chk("async_valid", int'(bus.valid), 0);
    chk("async_sel", int'({bus.S1, bus.S2}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // timeout hands off to source 3
    do_reset();
    cycle(1, 4'b1001, 0);
    chk("tmo_first", int'(bus.gnt), 4'b0001);
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      cycle(1, 4'b1001, 0);
      chk("tmo_hold", int'(bus.gnt), 4'b0001);
    end
    cycle(1, 4'b1001, 0);
    chk("tmo_switch_gnt", int'(bus.gnt), 4'b1000);
    chk("tmo_switch_sel", int'({bus.S1, bus.S2}), 3);

    // timeout with a single requester regrants it with a fresh count
    do_reset();
    cycle(1, 4'b0001, 0);
    for (int c = 0; c < MAX_HOLD; c++) cycle(1, 4'b0001, 0);
    chk("regrant_gnt", int'(bus.gnt), 4'b0001);
    check_model("regrant");
    for (int c = 0; c < DWELL - 1; c++) begin
      cycle(1, 4'b0000, 0);
      chk("regrant_dwell", int'(bus.gnt), 4'b0001);
    end
    cycle(1, 4'b0000, 0);
    chk("regrant_idle_valid", int'(bus.valid), 0);
    chk("regrant_idle_sel", int'({bus.S1, bus.S2}), 0);

    // random traffic against the model plus structural invariants
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      logic e, d;
      logic [3:0] r;
      e = ($urandom_range(0, 15) != 0);
      r = 4'($urandom);
      d = ($urandom_range(0, 3) == 0);
      cycle(e, r, d);
      check_model("rnd");
      chk("inv_onehot", int'($onehot0(bus.gnt)), 1);
      chk("inv_valid", int'(bus.valid), int'(bus.gnt != 4'b0));
      if (bus.valid) chk("inv_sel", int'(bus.gnt), 1 << {bus.S1, bus.S2});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
